// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for alu_arbiter; ovf exists only when ALU_ARBITER_OVF_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ*WIDTH-1:0] in0;
  logic [NUM_REQ*WIDTH-1:0] in1;
  logic [NUM_REQ*2-1:0]     sel;
  logic [WIDTH-1:0]         out;
  logic                     neg;
  logic                     pos;
  logic                     zero;
  logic [ID_W-1:0]          out_id;
  logic                     out_valid;
  logic                     out_ready;
`ifdef ALU_ARBITER_OVF_EN
  logic                     ovf;
`endif

  modport master (
    output req, in0, in1, sel, out_ready,
    input  ack, out, neg, pos, zero, out_id, out_valid
`ifdef ALU_ARBITER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  req, in0, in1, sel, out_ready,
    output ack, out, neg, pos, zero, out_id, out_valid
`ifdef ALU_ARBITER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered add/sub/and/or ALU among NUM_REQ requesters.
// Define ALU_ARBITER_OVF_EN to add a registered signed-overflow flag (ovf).
module alu_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [NUM_REQ-1:0]   r_ack, w_ack_d;
  logic [WIDTH-1:0]     r_a, w_a_d;
  logic [WIDTH-1:0]     r_b, w_b_d;
  logic [1:0]           r_op, w_op_d;
  logic [ID_W-1:0]      r_last, w_last_d;
  logic [WIDTH-1:0]     r_out, w_out_d;
  logic [ID_W-1:0]      r_out_id, w_out_id_d;
  logic                 r_neg, w_neg_d;
  logic                 r_pos, w_pos_d;
  logic                 r_zero, w_zero_d;
  logic                 r_valid, w_valid_d;
  logic [WIDTH-1:0]     w_res;
  logic [ID_W-1:0]      w_winner;

  // First set request strictly above last, otherwise the lowest set request (wrap-around).
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_winner = rr_pick(io_bus.req, r_last);

  always_comb begin
    w_res = '0;
    unique case (r_op)
      2'b00:   w_res = r_a + r_b;
      2'b01:   w_res = r_a - r_b;
      2'b10:   w_res = r_a & r_b;
      2'b11:   w_res = r_a | r_b;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ack    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_last   <= ID_W'(NUM_REQ - 1);
      r_out    <= '0;
      r_out_id <= '0;
      r_neg    <= 1'b0;
      r_pos    <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ack    <= w_ack_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_op     <= w_op_d;
      r_last   <= w_last_d;
      r_out    <= w_out_d;
      r_out_id <= w_out_id_d;
      r_neg    <= w_neg_d;
      r_pos    <= w_pos_d;
      r_zero   <= w_zero_d;
      r_valid  <= w_valid_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_ack_d    = '0;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_op_d     = r_op;
    w_last_d   = r_last;
    w_out_d    = r_out;
    w_out_id_d = r_out_id;
    w_neg_d    = r_neg;
    w_pos_d    = r_pos;
    w_zero_d   = r_zero;
    w_valid_d  = r_valid;
    unique case (r_state)
      StIdle: begin
        if (|io_bus.req) begin
          w_a_d     = io_bus.in0[w_winner*WIDTH +: WIDTH];
          w_b_d     = io_bus.in1[w_winner*WIDTH +: WIDTH];
          w_op_d    = io_bus.sel[w_winner*2 +: 2];
          w_last_d  = w_winner;
          w_ack_d   = NUM_REQ'(1) << w_winner;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        w_out_d    = w_res;
        w_out_id_d = r_last;
        w_neg_d    = w_res[WIDTH-1];
        w_pos_d    = !w_res[WIDTH-1] && (|w_res);
        w_zero_d   = ~|w_res;
        w_valid_d  = 1'b1;
        w_state_d  = StDone;
      end
      StDone: begin
        if (io_bus.out_ready) begin
          w_valid_d = 1'b0;
          w_neg_d   = 1'b0;
          w_pos_d   = 1'b0;
          w_zero_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef ALU_ARBITER_OVF_EN
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    unique case (r_op)
      2'b00:   w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      2'b01:   w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == StBusy) begin
      r_ovf <= w_ovf;
    end else if (r_state == StDone && io_bus.out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign io_bus.ovf = r_ovf;
`endif

  assign io_bus.ack       = r_ack;
  assign io_bus.out       = r_out;
  assign io_bus.neg       = r_neg;
  assign io_bus.pos       = r_pos;
  assign io_bus.zero      = r_zero;
  assign io_bus.out_id    = r_out_id;
  assign io_bus.out_valid = r_valid;

endmodule
